// File: rtl/fpadd_pkg.sv
// Shared types and constants for the fpadd writeback path.
// The entry layout here is the default FIFO payload when TAG_W matches DEF_TAG_W.
package fpadd_pkg;

  localparam int          FLAG_W    = 5;
  localparam int          DEF_TAG_W = 5;
  localparam logic        P_DOUBLE  = 1'b0;
  localparam logic        P_SINGLE  = 1'b1;
  localparam logic [31:0] NANBOX_HI = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [63:0]          res;
    logic [FLAG_W-1:0]    flags;
    logic                 denorm;
    logic [DEF_TAG_W-1:0] tag;
  } fp_wb_entry_t;

  // Single-precision results live in the low word with the upper word all-ones.
  function automatic logic [63:0] nanbox(input logic p, input logic [63:0] r);
    logic [63:0] v;
    v = r;
    case (p)
      P_SINGLE: v = {NANBOX_HI, r[31:0]};
      P_DOUBLE: v = r;
      default:  v = r;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/fpadd_wb_fifo.sv
// Registered DEPTH-entry FIFO with extra-MSB pointers for full/empty.
// When empty, the read port keeps presenting the last popped entry.
module fpadd_wb_fifo
  import fpadd_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fp_wb_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  entry_t wdata,
  input  logic   pop,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  entry_t        mem [DEPTH];
  entry_t        last_q;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? last_q : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        last_q <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/fpadd_wb_stage.sv
// Writeback buffer behind the combinational fpadd: NaN-boxes singles on entry,
// and on commit accumulates sticky fflags plus saturating op/denorm counters.
module fpadd_wb_stage
  import fpadd_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_result,
  input  logic [4:0]       in_flags,
  input  logic             in_denorm,
  input  logic             in_p,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [4:0]       out_flags,
  output logic             out_denorm,
  output logic [TAG_W-1:0] out_tag,
  input  logic             fflags_clr,
  output logic [4:0]       fflags,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] dn_count
);

  // Same layout as fp_wb_entry_t, but sized by this instance's TAG_W.
  typedef struct packed {
    logic [63:0]       res;
    logic [FLAG_W-1:0] flags;
    logic              denorm;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  entry_t wdata, head;
  logic   full, empty, push, pop;

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wdata        = '0;
    wdata.res    = nanbox(in_p, in_result);
    wdata.flags  = in_flags;
    wdata.denorm = in_denorm;
    wdata.tag    = in_tag;
  end

  fpadd_wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign out_result = head.res;
  assign out_flags  = head.flags;
  assign out_denorm = head.denorm;
  assign out_tag    = head.tag;

  // A clear racing a commit keeps the committed flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fflags   <= '0;
      op_count <= '0;
      dn_count <= '0;
    end else begin
      fflags <= (fflags_clr ? 5'b0 : fflags) | (pop ? head.flags : 5'b0);
      if (pop && (op_count != '1))
        op_count <= op_count + CNT_W'(1);
      if (pop && head.denorm && (dn_count != '1))
        dn_count <= dn_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fpadd_wb_stage.sv
// Randomized and directed bench for fpadd_wb_stage against a queue-based model.
module tb_fpadd_wb_stage;

  localparam int DEPTH = 2;
  localparam int TAG_W = 5;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0, in_denorm = 1'b0, in_p = 1'b0;
  logic             out_ready = 1'b0, fflags_clr = 1'b0;
  logic [63:0]      in_result = '0;
  logic [4:0]       in_flags = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             in_ready, out_valid, out_denorm;
  logic [63:0]      out_result;
  logic [4:0]       out_flags, fflags;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] op_count, dn_count;

  fpadd_wb_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_flags(in_flags), .in_denorm(in_denorm), .in_p(in_p), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_denorm(out_denorm), .out_tag(out_tag),
    .fflags_clr(fflags_clr), .fflags(fflags), .op_count(op_count), .dn_count(dn_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]      res;
    logic [4:0]       fl;
    logic             dn;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t             mq[$];
  ent_t             mlast = '{res: '0, fl: '0, dn: 1'b0, tag: '0};
  logic [4:0]       mff = '0;
  logic [CNT_W-1:0] mop = '0, mdn = '0;
  int               total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a bounded queue of what the consumer should see, in order.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      mlast = '{res: '0, fl: '0, dn: 1'b0, tag: '0};
      mff = '0; mop = '0; mdn = '0;
    end else begin
      ent_t h, n;
      logic pm, um;
      pm = (mq.size() != 0) && out_ready;
      um = in_valid && (mq.size() < DEPTH);
      h = mlast;
      if (pm) begin
        h = mq.pop_front();
        mlast = h;
      end
      mff = (fflags_clr ? 5'b0 : mff) | (pm ? h.fl : 5'b0);
      if (pm && mop != {CNT_W{1'b1}}) mop = mop + 1'b1;
      if (pm && h.dn && mdn != {CNT_W{1'b1}}) mdn = mdn + 1'b1;
      if (um) begin
        n.res = in_p ? {32'hFFFF_FFFF, in_result[31:0]} : in_result;
        n.fl  = in_flags;
        n.dn  = in_denorm;
        n.tag = in_tag;
        mq.push_back(n);
      end
    end
  end

  // Every cycle: DUT outputs vs model, sampled away from the rising edge.
  always @(negedge clk) begin
    ent_t hd;
    hd = (mq.size() != 0) ? mq[0] : mlast;
    chk("out_valid",  64'(out_valid),  64'(mq.size() != 0));
    chk("in_ready",   64'(in_ready),   64'(mq.size() < DEPTH));
    chk("out_result", out_result,      hd.res);
    chk("out_flags",  64'(out_flags),  64'(hd.fl));
    chk("out_denorm", 64'(out_denorm), 64'(hd.dn));
    chk("out_tag",    64'(out_tag),    64'(hd.tag));
    chk("fflags",     64'(fflags),     64'(mff));
    chk("op_count",   64'(op_count),   64'(mop));
    chk("dn_count",   64'(dn_count),   64'(mdn));
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Producer holds its op until accepted.
  task automatic send(input logic [63:0] r, input logic [4:0] f, input logic d,
                      input logic p, input logic [TAG_W-1:0] t);
    in_valid = 1'b1; in_result = r; in_flags = f; in_denorm = d; in_p = p; in_tag = t;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        step();
        in_valid = 1'b0;
        return;
      end
      step();
    end
    total++; bad++;
    $display("FAIL send_timeout: in_ready stayed 0, required 1");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (!out_valid) begin
        out_ready = 1'b0;
        return;
      end
      step();
    end
    total++; bad++;
    $display("FAIL drain_timeout: out_valid stayed 1, required 0");
    out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; step(); reset = 1'b0; step();
  endtask

  initial begin
    step(); step();
    reset = 1'b0;
    step();

    // Latency: visible the cycle after push, committed the cycle after pop.
    out_ready = 1'b1;
    in_valid = 1'b1; in_result = 64'h3FF0_0000_0000_0000; in_flags = 5'b00001;
    in_denorm = 1'b0; in_p = 1'b0; in_tag = 5'd3;
    step();
    in_valid = 1'b0;
    chk("lat_valid",  64'(out_valid), 64'd1);
    chk("lat_result", out_result,     64'h3FF0_0000_0000_0000);
    chk("lat_tag",    64'(out_tag),   64'd3);
    step();
    chk("lat_fflags", 64'(fflags),    64'h01);
    chk("lat_opcnt",  64'(op_count),  64'd1);
    chk("lat_empty",  64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Backpressure: two fill the buffer, third waits, drain in order.
    send(64'h4000_0000_0000_0001, 5'b00010, 1'b0, 1'b0, 5'd4);
    send(64'h4000_0000_0000_0002, 5'b00100, 1'b1, 1'b0, 5'd5);
    chk("full_ready", 64'(in_ready), 64'd0);
    chk("full_head",  out_result,    64'h4000_0000_0000_0001);
    out_ready = 1'b1;
    send(64'h4000_0000_0000_0003, 5'b01000, 1'b0, 1'b0, 5'd6);
    drain();
    chk("full_opcnt", 64'(op_count), 64'd4);
    chk("full_dncnt", 64'(dn_count), 64'd1);

    // NaN-boxing of single results; doubles pass untouched.
    send(64'h0000_0000_3F80_0000, 5'b0, 1'b0, 1'b1, 5'd7);
    chk("nanbox_single", out_result, 64'hFFFF_FFFF_3F80_0000);
    drain();
    send(64'h0000_0000_3F80_0000, 5'b0, 1'b0, 1'b0, 5'd8);
    chk("nanbox_double", out_result, 64'h0000_0000_3F80_0000);
    drain();

    // Sticky clear racing a commit.
    fflags_clr = 1'b1; step(); fflags_clr = 1'b0;
    send(64'h1, 5'b10000, 1'b0, 1'b0, 5'd9);
    drain();
    chk("sticky_pre", 64'(fflags), 64'h10);
    send(64'h2, 5'b00100, 1'b0, 1'b0, 5'd10);
    out_ready = 1'b1; fflags_clr = 1'b1;
    step();
    out_ready = 1'b0; fflags_clr = 1'b0;
    chk("sticky_race", 64'(fflags), 64'h04);

    // Denorm counter pinned at all-ones; op counter keeps counting.
    pulse_reset();
    force dut.dn_count = {CNT_W{1'b1}};
    mdn = {CNT_W{1'b1}};
    step();
    release dut.dn_count;
    send(64'h3, 5'b0, 1'b1, 1'b0, 5'd11);
    drain();
    chk("sat_dncnt", 64'(dn_count), 64'hFF);
    chk("sat_opcnt", 64'(op_count), 64'd1);

    // Random traffic; long enough to saturate op_count.
    for (int i = 0; i < 700; i++) begin
      in_valid   = 1'($urandom_range(0, 1));
      out_ready  = ($urandom_range(0, 9) < 6);
      fflags_clr = ($urandom_range(0, 19) == 0);
      in_result  = {$urandom, $urandom};
      in_flags   = 5'($urandom);
      in_denorm  = 1'($urandom);
      in_p       = 1'($urandom);
      in_tag     = TAG_W'($urandom);
      step();
    end
    in_valid = 1'b0; fflags_clr = 1'b0;
    chk("rand_opsat", 64'(op_count), 64'hFF);

    // Asynchronous reset mid-burst with two entries held.
    out_ready = 1'b0;
    drain();
    out_ready = 1'b0;
    send(64'hAAAA, 5'b11111, 1'b1, 1'b0, 5'd1);
    send(64'hBBBB, 5'b11111, 1'b1, 1'b0, 5'd2);
    in_valid = 1'b1; in_result = 64'hCCCC;
    #2 reset = 1'b1;
    #1;
    chk("rst_valid",  64'(out_valid), 64'd0);
    chk("rst_ready",  64'(in_ready),  64'd1);
    chk("rst_fflags", 64'(fflags),    64'd0);
    chk("rst_opcnt",  64'(op_count),  64'd0);
    chk("rst_result", out_result,     64'd0);
    step();
    in_valid = 1'b0;
    reset = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
